ldpc_3gpp_enc_reg_sched: RTL

LDPC_3GPP_ENC_REG_SCHED -- requirements
Module: ldpc_3gpp_enc_reg_sched

---
 rtl/ldpc_3gpp_enc_reg_sched_pkg.sv | 23 ++
 rtl/ldpc_3gpp_enc_reg_sched_if.sv | 29 ++
 rtl/ldpc_3gpp_enc_rr_arb2.sv | 36 +++
 rtl/ldpc_3gpp_enc_reg_sched.sv | 82 ++++++++
 4 files changed

// File: rtl/ldpc_3gpp_enc_reg_sched_pkg.sv
// Shared encoder types for the matrix-register sequencer: FSM/burst encodings
// and the read latency of the sequenced single-port register.
package ldpc_3gpp_enc_reg_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   typedef enum logic {
      BURST_WR = 1'b0,
      BURST_RD = 1'b1
   } burst_t;

   localparam int REG_LAT_BASE = 3;

   // register read latency in ticks for a given extra pipeline depth
   function automatic int reg_rd_lat(input int pipe);
      return REG_LAT_BASE + pipe;
   endfunction

endpackage

// File: rtl/ldpc_3gpp_enc_reg_sched_if.sv
// Request/grant and strobe bundle between the sequencer and its clients.
interface ldpc_3gpp_enc_reg_sched_if #(
   parameter int pADDR_W = 8
);
   logic [pADDR_W-1:0] ilen;
   logic               iwr_req;
   logic               ird_req;
   logic               owr_ack;
   logic               ord_ack;
   logic               owrite;
   logic               owstart;
   logic               oread;
   logic               orstart;
   logic               owr_done;
   logic               ord_done;
   logic               obusy;

   modport master (
      output ilen, iwr_req, ird_req,
      input  owr_ack, ord_ack, owrite, owstart, oread, orstart,
             owr_done, ord_done, obusy
   );

   modport slave (
      input  ilen, iwr_req, ird_req,
      output owr_ack, ord_ack, owrite, owstart, oread, orstart,
             owr_done, ord_done, obusy
   );
endinterface

// File: rtl/ldpc_3gpp_enc_rr_arb2.sv
// Two-way round-robin arbiter: write vs read, write has priority after reset.
module ldpc_3gpp_enc_rr_arb2
   import ldpc_3gpp_enc_reg_sched_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clkena,
   input  logic take,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt_wr,
   output logic gnt_rd
);

   burst_t prio;

   always_comb begin
      gnt_wr = 1'b0;
      gnt_rd = 1'b0;
      if (take) begin
         gnt_wr = req_wr & (~req_rd | (prio == BURST_WR));
         gnt_rd = req_rd & (~req_wr | (prio == BURST_RD));
      end
   end

   // after a grant the other type owns priority, so neither side can starve
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= BURST_WR;
      end else if (clkena) begin
         if (gnt_wr)      prio <= BURST_RD;
         else if (gnt_rd) prio <= BURST_WR;
      end
   end

endmodule

// File: rtl/ldpc_3gpp_enc_reg_sched.sv
// Burst sequencer for the single-port LDPC matrix register: arbitrates write
// and read bursts, generates strobes and tracks read data in flight.
module ldpc_3gpp_enc_reg_sched
   import ldpc_3gpp_enc_reg_sched_pkg::*;
#(
   parameter int pADDR_W = 8,
   parameter int pPIPE   = 0
)(
   input  logic                        iclk,
   input  logic                        ireset_n,
   input  logic                        iclkena,
   ldpc_3gpp_enc_reg_sched_if.slave    bus
);

   localparam int LAT = reg_rd_lat(pPIPE);

   state_t             state, state_nxt;
   logic [pADDR_W-1:0] cnt, cnt_nxt;
   logic [pADDR_W-1:0] len, len_nxt;
   logic [LAT-1:0]     done_pipe;
   logic               last, take, grant, rd_last;
   logic               gnt_wr, gnt_rd;

   assign last    = (state != ST_IDLE) && (cnt == len);
   assign rd_last = (state == ST_READ) && last;
   // grants are only taken from idle or on the final word (back-to-back)
   assign take    = iclkena & ireset_n & ((state == ST_IDLE) | last);
   assign grant   = gnt_wr | gnt_rd;

   ldpc_3gpp_enc_rr_arb2 u_arb (
      .clk    (iclk),
      .rst_n  (ireset_n),
      .clkena (iclkena),
      .take   (take),
      .req_wr (bus.iwr_req),
      .req_rd (bus.ird_req),
      .gnt_wr (gnt_wr),
      .gnt_rd (gnt_rd)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len;
      if (grant) begin
         state_nxt = gnt_wr ? ST_WRITE : ST_READ;
         cnt_nxt   = '0;
         len_nxt   = bus.ilen;
      end else if (last) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
      end else if (state != ST_IDLE) begin
         cnt_nxt   = cnt + 1'b1;
      end
   end

   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         len       <= '0;
         done_pipe <= '0;
      end else if (iclkena) begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         len       <= len_nxt;
         done_pipe <= {done_pipe[LAT-2:0], rd_last};
      end
   end

   assign bus.owr_ack  = gnt_wr;
   assign bus.ord_ack  = gnt_rd;
   assign bus.owrite   = (state == ST_WRITE);
   assign bus.owstart  = (state == ST_WRITE) && (cnt == '0);
   assign bus.owr_done = (state == ST_WRITE) && last;
   assign bus.oread    = (state == ST_READ);
   assign bus.orstart  = (state == ST_READ) && (cnt == '0);
   assign bus.ord_done = done_pipe[LAT-1];
   // each read burst owns its own bit in the pipe, so overlapping dones survive
   assign bus.obusy    = (state != ST_IDLE) || (|done_pipe);

endmodule
